// File: rtl/text_pkg.sv
// Shared types and constants for the text line renderer and its reveal FSM.
package text_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REVEAL = 2'd1,
    ST_DONE   = 2'd2
  } reveal_state_e;

  localparam int SPACE_CODE   = 0;
  localparam int CURSOR_ROWS  = 2;
  localparam int BLINK_PERIOD = 16;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/text_reveal_fsm.sv
// Frame-paced typewriter reveal: counts frame_ticks and grows the visible prefix.
// Optional cursor blink flop is built when TEXT_CURSOR_BLINK_EN is defined.
module text_reveal_fsm
  import text_pkg::*;
#(
  parameter int N_CHARS       = 16,
  parameter int REVEAL_FRAMES = 4,
  parameter int VIS_W         = width_of(N_CHARS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_reveal,
  input  logic             frame_tick,
  output logic [VIS_W-1:0] vis_count,
  output logic             busy,
  output logic             reveal_done
`ifdef TEXT_CURSOR_BLINK_EN
  ,
  output logic             blink
`endif
);

  localparam int FC_W = width_of(REVEAL_FRAMES);
  localparam logic [VIS_W-1:0] VIS_ALL = VIS_W'(N_CHARS);
  localparam logic [FC_W-1:0]  FC_LAST = FC_W'(REVEAL_FRAMES - 1);

  reveal_state_e    state, state_nxt;
  logic [FC_W-1:0]  frame_cnt, frame_cnt_nxt;
  logic [VIS_W-1:0] vis_nxt;
  logic             done_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      frame_cnt   <= '0;
      vis_count   <= VIS_ALL;
      reveal_done <= 1'b0;
    end else begin
      state       <= state_nxt;
      frame_cnt   <= frame_cnt_nxt;
      vis_count   <= vis_nxt;
      reveal_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    frame_cnt_nxt = frame_cnt;
    vis_nxt       = vis_count;
    done_nxt      = 1'b0;
    // start_reveal restarts from any state and wins over a same-cycle tick
    if (start_reveal) begin
      state_nxt     = ST_REVEAL;
      frame_cnt_nxt = '0;
      vis_nxt       = '0;
    end else begin
      unique case (state)
        ST_REVEAL: begin
          if (frame_tick) begin
            if (frame_cnt == FC_LAST) begin
              frame_cnt_nxt = '0;
              vis_nxt       = vis_count + VIS_W'(1);
              if (vis_nxt == VIS_ALL) begin
                state_nxt = ST_DONE;
                done_nxt  = 1'b1;
              end
            end else begin
              frame_cnt_nxt = frame_cnt + FC_W'(1);
            end
          end
        end
        default: vis_nxt = VIS_ALL;
      endcase
    end
  end

  assign busy = (state == ST_REVEAL);

`ifdef TEXT_CURSOR_BLINK_EN
  localparam int BL_W = width_of(BLINK_PERIOD);
  logic [BL_W-1:0] blink_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      blink     <= 1'b1;
    end else if (frame_tick) begin
      if (blink_cnt == BL_W'(BLINK_PERIOD - 1)) begin
        blink_cnt <= '0;
        blink     <= ~blink;
      end else begin
        blink_cnt <= blink_cnt + BL_W'(1);
      end
    end
  end
`endif

endmodule

// File: rtl/text_line_renderer.sv
// Single-line string renderer: character buffer plus 2-stage scan-to-font-address pipeline.
// Cursor underline is built when TEXT_CURSOR_BLINK_EN is defined, otherwise cursor_px is 0.
module text_line_renderer
  import text_pkg::*;
#(
  parameter int CNT_WIDTH     = 10,
  parameter int ADDR_WIDTH    = 17,
  parameter int N_CHARS       = 16,
  parameter int CODE_WIDTH    = 5,
  parameter int CHAR_W        = 15,
  parameter int CHAR_H        = 30,
  parameter int FONT_IMG_W    = 405,
  parameter int SCALE_SHIFT   = 0,
  parameter int REVEAL_FRAMES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CNT_WIDTH-1:0]  h_cnt,
  input  logic [CNT_WIDTH-1:0]  v_cnt,
  input  logic [CNT_WIDTH-1:0]  h_start,
  input  logic [CNT_WIDTH-1:0]  v_start,
  input  logic                  wr_en,
  input  logic [5:0]            wr_idx,
  input  logic [CODE_WIDTH-1:0] wr_code,
  input  logic                  clear,
  input  logic                  start_reveal,
  input  logic                  frame_tick,
  output logic [ADDR_WIDTH-1:0] pixel_addr,
  output logic                  pixel_valid,
  output logic                  cursor_px,
  output logic                  busy,
  output logic                  reveal_done
);

  localparam int VIS_W = width_of(N_CHARS + 1);
  localparam int COL_W = width_of(CHAR_W);
  localparam int ROW_W = width_of(CHAR_H);
  localparam int SPAN  = N_CHARS * CHAR_W;

  logic [CODE_WIDTH-1:0] char_buf [N_CHARS];
  logic [VIS_W-1:0]      vis_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CHARS; i++) char_buf[i] <= CODE_WIDTH'(SPACE_CODE);
    end else if (clear) begin
      for (int i = 0; i < N_CHARS; i++) char_buf[i] <= CODE_WIDTH'(SPACE_CODE);
    end else if (wr_en) begin
      // Out-of-range indices match no slot and are dropped.
      for (int i = 0; i < N_CHARS; i++)
        if (wr_idx == 6'(i)) char_buf[i] <= wr_code;
    end
  end

  // ---- stage 1: scan position -> slot / column / row ----
  logic [CNT_WIDTH-1:0] dx_p0, dy_p0, sx_p0, sy_p0;
  logic                 vld_p0;
  logic [VIS_W-1:0]     slot_p0;
  logic [COL_W-1:0]     col_p0;
  logic [ROW_W-1:0]     row_p0;

  always_comb begin
    dx_p0   = h_cnt - h_start;
    dy_p0   = v_cnt - v_start;
    sx_p0   = dx_p0 >> SCALE_SHIFT;
    sy_p0   = dy_p0 >> SCALE_SHIFT;
    vld_p0  = (h_cnt >= h_start) && (v_cnt >= v_start) &&
              (int'(sx_p0) < SPAN) && (int'(sy_p0) < CHAR_H);
    slot_p0 = VIS_W'(int'(sx_p0) / CHAR_W);
    col_p0  = COL_W'(int'(sx_p0) % CHAR_W);
    row_p0  = ROW_W'(sy_p0);
  end

  logic             vld_p1;
  logic [VIS_W-1:0] slot_p1;
  logic [COL_W-1:0] col_p1;
  logic [ROW_W-1:0] row_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    slot_p1 <= slot_p0;
    col_p1  <= col_p0;
    row_p1  <= row_p0;
  end

  // ---- stage 2: glyph lookup -> font ROM address ----
  logic [CODE_WIDTH-1:0] code_p1;
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic                  show_p1;

  always_comb begin
    code_p1 = CODE_WIDTH'(SPACE_CODE);
    for (int i = 0; i < N_CHARS; i++)
      if (slot_p1 == VIS_W'(i)) code_p1 = char_buf[i];
    addr_p1 = ADDR_WIDTH'(int'(code_p1) * CHAR_W + int'(col_p1) + FONT_IMG_W * int'(row_p1));
    show_p1 = vld_p1 && (slot_p1 < vis_count);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_valid <= 1'b0;
      pixel_addr  <= '0;
    end else begin
      pixel_valid <= show_p1;
      pixel_addr  <= show_p1 ? addr_p1 : '0;
    end
  end

`ifdef TEXT_CURSOR_BLINK_EN
  logic blink;
  logic cursor_p1;

  // slot == vis_count can only hold while vis_count < N_CHARS, since slot < N_CHARS when in range.
  assign cursor_p1 = busy && blink && vld_p1 && (slot_p1 == vis_count) &&
                     (int'(row_p1) >= CHAR_H - CURSOR_ROWS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cursor_px <= 1'b0;
    else     cursor_px <= cursor_p1;
  end
`else
  assign cursor_px = 1'b0;
`endif

  text_reveal_fsm #(
    .N_CHARS       (N_CHARS),
    .REVEAL_FRAMES (REVEAL_FRAMES),
    .VIS_W         (VIS_W)
  ) u_reveal (
    .clk          (clk),
    .rst          (rst),
    .start_reveal (start_reveal),
    .frame_tick   (frame_tick),
    .vis_count    (vis_count),
    .busy         (busy),
    .reveal_done  (reveal_done)
`ifdef TEXT_CURSOR_BLINK_EN
    ,
    .blink        (blink)
`endif
  );

endmodule

// File: tb/tb_text_line_renderer.sv
// Scoreboard bench for text_line_renderer (default parameters); cursor checks follow TEXT_CURSOR_BLINK_EN.
module tb_text_line_renderer;

  localparam int N  = 16;
  localparam int CW = 15;
  localparam int CH = 30;
  localparam int FW = 405;

  logic        clk, rst;
  logic [9:0]  h_cnt, v_cnt, h_start, v_start;
  logic        wr_en;
  logic [5:0]  wr_idx;
  logic [4:0]  wr_code;
  logic        clear, start_reveal, frame_tick;
  logic [16:0] pixel_addr;
  logic        pixel_valid, cursor_px, busy, reveal_done;

  typedef struct packed {
    logic        valid;
    logic [16:0] addr;
    logic        cur;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   done_pulses = 0;

  // Reference state kept by the bench from the stimulus it applies.
  int m_buf[N];
  int m_vis, m_hs, m_vs, m_ticks;
  bit m_busy;

  text_line_renderer dut (
    .clk          (clk),
    .rst          (rst),
    .h_cnt        (h_cnt),
    .v_cnt        (v_cnt),
    .h_start      (h_start),
    .v_start      (v_start),
    .wr_en        (wr_en),
    .wr_idx       (wr_idx),
    .wr_code      (wr_code),
    .clear        (clear),
    .start_reveal (start_reveal),
    .frame_tick   (frame_tick),
    .pixel_addr   (pixel_addr),
    .pixel_valid  (pixel_valid),
    .cursor_px    (cursor_px),
    .busy         (busy),
    .reveal_done  (reveal_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (reveal_done === 1'b1) done_pulses <= done_pulses + 1;

  function automatic exp_t model_px(input int h, input int v);
    exp_t e;
    int   dx, dy, slot, col;
    bit   in_r;
    dx   = (h - m_hs) & 1023;
    dy   = (v - m_vs) & 1023;
    in_r = (h >= m_hs) && (v >= m_vs) && (dx < N * CW) && (dy < CH);
    slot = dx / CW;
    col  = dx % CW;
    e    = '0;
    e.valid = in_r && (slot < m_vis);
    if (e.valid) e.addr = 17'((m_buf[slot] * CW + col + FW * dy) & 32'h1FFFF);
`ifdef TEXT_CURSOR_BLINK_EN
    e.cur = m_busy && (((m_ticks / 16) % 2) == 0) && in_r && (slot == m_vis) && (dy >= CH - 2);
`endif
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_buf[i] = 0;
    m_vis = N; m_busy = 0; m_ticks = 0;
  endtask

  task automatic wr(input int idx, input int code);
    @(negedge clk);
    wr_en = 1'b1; wr_idx = 6'(idx); wr_code = 5'(code);
    @(negedge clk);
    wr_en = 1'b0;
    if (idx < N) m_buf[idx] = code;
  endtask

  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    m_ticks++;
  endtask

  task automatic start();
    @(negedge clk);
    start_reveal = 1'b1;
    @(negedge clk);
    start_reveal = 1'b0;
    m_vis = 0; m_busy = 1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    vectors++;
    if ({pixel_valid, pixel_addr, cursor_px, busy, reveal_done} !== 21'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: valid=%b addr=%0d cur=%b busy=%b done=%b, need all 0",
               pixel_valid, pixel_addr, cursor_px, busy, reveal_done);
    end
    model_reset();
    h_start = 10'd100; v_start = 10'd50; m_hs = 100; m_vs = 50;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    begin
      int   ph[$] = '{117, 339};
      int   pv[$] = '{52, 79};
      exp_t pe[$];
      exp_t e;
      pe.push_back('{1'b1, 17'd812, 1'b0});
      pe.push_back('{1'b1, 17'd11759, 1'b0});
      for (int i = 0; i < ph.size() + 2; i++) begin
        @(negedge clk);
        if (i >= 2) begin
          e = sb.pop_front();
          vectors++;
          if ({pixel_valid, pixel_addr, cursor_px} !== {e.valid, e.addr, e.cur}) begin
            miscompares++;
            $display("FAIL reset_state px%0d: got valid=%b addr=%0d cur=%b, need valid=%b addr=%0d cur=%b",
                     i - 2, pixel_valid, pixel_addr, cursor_px, e.valid, e.addr, e.cur);
          end
        end
        if (i < ph.size()) begin
          h_cnt = 10'(ph[i]); v_cnt = 10'(pv[i]); sb.push_back(pe[i]);
        end
      end
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy: got %b, need 0", busy);
    end
  endtask

  task automatic test_render();
    int   ph[$] = '{117, 100, 339, 144, 110};
    int   pv[$] = '{52, 50, 79, 60, 70};
    exp_t pe[$];
    exp_t e;
    wr(1, 3);
    wr(15, 26);
    wr(2, 9);
    pe.push_back('{1'b1, 17'd857, 1'b0});
    pe.push_back('{1'b1, 17'd0, 1'b0});
    pe.push_back('{1'b1, 17'd12149, 1'b0});
    pe.push_back(model_px(144, 60));
    pe.push_back(model_px(110, 70));
    for (int i = 0; i < ph.size() + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        e = sb.pop_front();
        vectors++;
        if ({pixel_valid, pixel_addr, cursor_px} !== {e.valid, e.addr, e.cur}) begin
          miscompares++;
          $display("FAIL render px%0d: got valid=%b addr=%0d cur=%b, need valid=%b addr=%0d cur=%b",
                   i - 2, pixel_valid, pixel_addr, cursor_px, e.valid, e.addr, e.cur);
        end
      end
      if (i < ph.size()) begin
        h_cnt = 10'(ph[i]); v_cnt = 10'(pv[i]); sb.push_back(pe[i]);
      end
    end
  endtask

  task automatic test_bounds();
    int   ph[$] = '{99, 340, 100, 100, 339};
    int   pv[$] = '{50, 50, 49, 80, 79};
    exp_t pe[$];
    exp_t e;
    pe.push_back('{1'b0, 17'd0, 1'b0});
    pe.push_back('{1'b0, 17'd0, 1'b0});
    pe.push_back('{1'b0, 17'd0, 1'b0});
    pe.push_back('{1'b0, 17'd0, 1'b0});
    pe.push_back('{1'b1, 17'd12149, 1'b0});
    wr(20, 9);
    wr(16, 11);
    for (int s = 0; s < N; s++) begin
      ph.push_back(100 + 15 * s); pv.push_back(50); pe.push_back(model_px(100 + 15 * s, 50));
    end
    for (int i = 0; i < ph.size() + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        e = sb.pop_front();
        vectors++;
        if ({pixel_valid, pixel_addr, cursor_px} !== {e.valid, e.addr, e.cur}) begin
          miscompares++;
          $display("FAIL bounds px%0d: got valid=%b addr=%0d cur=%b, need valid=%b addr=%0d cur=%b",
                   i - 2, pixel_valid, pixel_addr, cursor_px, e.valid, e.addr, e.cur);
        end
      end
      if (i < ph.size()) begin
        h_cnt = 10'(ph[i]); v_cnt = 10'(pv[i]); sb.push_back(pe[i]);
      end
    end
  endtask

  task automatic test_reveal();
    int   ph[$] = '{130, 117, 100};
    int   pv[$] = '{50, 52, 50};
    exp_t pe[$];
    exp_t e;
    int   d0;
    start();
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reveal_busy: got %b, need 1", busy);
    end
    repeat (8) tick();
    m_vis = 2;
    pe.push_back('{1'b0, 17'd0, 1'b0});
    pe.push_back('{1'b1, 17'd857, 1'b0});
    pe.push_back(model_px(100, 50));
    for (int i = 0; i < ph.size() + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        e = sb.pop_front();
        vectors++;
        if ({pixel_valid, pixel_addr, cursor_px} !== {e.valid, e.addr, e.cur}) begin
          miscompares++;
          $display("FAIL reveal_partial px%0d: got valid=%b addr=%0d cur=%b, need valid=%b addr=%0d cur=%b",
                   i - 2, pixel_valid, pixel_addr, cursor_px, e.valid, e.addr, e.cur);
        end
      end
      if (i < ph.size()) begin
        h_cnt = 10'(ph[i]); v_cnt = 10'(pv[i]); sb.push_back(pe[i]);
      end
    end
    d0 = done_pulses;
    repeat (55) tick();
    @(negedge clk);
    vectors++;
    if ({busy, 32'(done_pulses - d0)} !== {1'b1, 32'd0}) begin
      miscompares++;
      $display("FAIL reveal_63_ticks: got busy=%b pulses=%0d, need busy=1 pulses=0", busy, done_pulses - d0);
    end
    tick();
    repeat (4) @(negedge clk);
    vectors++;
    if ({busy, 32'(done_pulses - d0)} !== {1'b0, 32'd1}) begin
      miscompares++;
      $display("FAIL reveal_done: got busy=%b pulses=%0d, need busy=0 pulses=1", busy, done_pulses - d0);
    end
    m_vis = N; m_busy = 0;
  endtask

  task automatic test_clear_priority();
    int   ph[$] = '{100, 117, 339, 130};
    int   pv[$] = '{50, 52, 79, 51};
    exp_t pe[$];
    exp_t e;
    @(negedge clk);
    wr_en = 1'b1; wr_idx = 6'd0; wr_code = 5'd7; clear = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; clear = 1'b0;
    for (int s = 0; s < N; s++) m_buf[s] = 0;
    pe.push_back('{1'b1, 17'd0, 1'b0});
    pe.push_back('{1'b1, 17'd812, 1'b0});
    pe.push_back('{1'b1, 17'd11759, 1'b0});
    pe.push_back(model_px(130, 51));
    for (int i = 0; i < ph.size() + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        e = sb.pop_front();
        vectors++;
        if ({pixel_valid, pixel_addr, cursor_px} !== {e.valid, e.addr, e.cur}) begin
          miscompares++;
          $display("FAIL clear_priority px%0d: got valid=%b addr=%0d cur=%b, need valid=%b addr=%0d cur=%b",
                   i - 2, pixel_valid, pixel_addr, cursor_px, e.valid, e.addr, e.cur);
        end
      end
      if (i < ph.size()) begin
        h_cnt = 10'(ph[i]); v_cnt = 10'(pv[i]); sb.push_back(pe[i]);
      end
    end
  endtask

  task automatic test_restart();
    int   ph[$];
    int   pv[$];
    exp_t pe[$];
    exp_t e;
    wr(0, 4);
    start();
    repeat (5) tick();
    @(negedge clk);
    start_reveal = 1'b1; frame_tick = 1'b1;
    @(negedge clk);
    start_reveal = 1'b0; frame_tick = 1'b0;
    m_ticks++; m_vis = 0;
    repeat (3) tick();
    for (int phase = 0; phase < 2; phase++) begin
      if (phase == 1) begin
        tick();
        m_vis = 1;
      end
      ph = '{105, 120};
      pv = '{53, 53};
      pe.delete();
      pe.push_back(model_px(105, 53));
      pe.push_back(model_px(120, 53));
      for (int i = 0; i < ph.size() + 2; i++) begin
        @(negedge clk);
        if (i >= 2) begin
          e = sb.pop_front();
          vectors++;
          if ({pixel_valid, pixel_addr, cursor_px} !== {e.valid, e.addr, e.cur}) begin
            miscompares++;
            $display("FAIL restart ph%0d px%0d: got valid=%b addr=%0d cur=%b, need valid=%b addr=%0d cur=%b",
                     phase, i - 2, pixel_valid, pixel_addr, cursor_px, e.valid, e.addr, e.cur);
          end
        end
        if (i < ph.size()) begin
          h_cnt = 10'(ph[i]); v_cnt = 10'(pv[i]); sb.push_back(pe[i]);
        end
      end
    end
  endtask

`ifdef TEXT_CURSOR_BLINK_EN
  task automatic test_cursor();
    exp_t pe[$];
    exp_t e;
    int   tries = 0;
    do begin
      start();
      repeat (8) tick();
      m_vis = 2;
      tries++;
    end while ((((m_ticks / 16) % 2) != 0) && (tries < 4));
    for (int phase = 0; phase < 2; phase++) begin
      if (phase == 1) begin
        repeat (16) tick();
        m_vis = 6;
      end
      pe.delete();
      pe.push_back(phase == 0 ? exp_t'('{1'b0, 17'd0, 1'b1}) : model_px(130, 79));
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (i >= 2) begin
          e = sb.pop_front();
          vectors++;
          if ({pixel_valid, pixel_addr, cursor_px} !== {e.valid, e.addr, e.cur}) begin
            miscompares++;
            $display("FAIL cursor ph%0d: got valid=%b addr=%0d cur=%b, need valid=%b addr=%0d cur=%b",
                     phase, pixel_valid, pixel_addr, cursor_px, e.valid, e.addr, e.cur);
          end
        end
        if (i == 0) begin
          h_cnt = 10'd130; v_cnt = 10'd79; sb.push_back(pe[0]);
        end
      end
    end
  endtask
`endif

  task automatic test_async_reset();
    exp_t e;
    @(negedge clk);
    h_cnt = 10'd105; v_cnt = 10'd53;
    e = model_px(105, 53);
    repeat (2) @(negedge clk);
    vectors++;
    if ({pixel_valid, pixel_addr, busy} !== {e.valid, e.addr, 1'b1} || pixel_addr === 17'd0) begin
      miscompares++;
      $display("FAIL pre_reset: got valid=%b addr=%0d busy=%b, need valid=%b addr=%0d busy=1",
               pixel_valid, pixel_addr, busy, e.valid, e.addr);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({pixel_valid, pixel_addr, cursor_px, busy, reveal_done} !== 21'd0) begin
      miscompares++;
      $display("FAIL async_reset: valid=%b addr=%0d cur=%b busy=%b done=%b, need all 0",
               pixel_valid, pixel_addr, cursor_px, busy, reveal_done);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    h_cnt = '0; v_cnt = '0; h_start = '0; v_start = '0;
    wr_en = 1'b0; wr_idx = '0; wr_code = '0; clear = 1'b0;
    start_reveal = 1'b0; frame_tick = 1'b0;
    test_reset();
    test_render();
    test_bounds();
    test_reveal();
    test_clear_priority();
    test_restart();
`ifdef TEXT_CURSOR_BLINK_EN
    test_cursor();
`endif
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
